rtc_time_reader: RTL and testbench

RTC_TIME_READER -- requirements
Module: rtc_time_reader

---
 rtl/rtc_pkg.sv | 26 ++
 rtl/rtc_time_reader_if.sv | 52 +++++
 rtl/bcd_to_binary.sv | 25 ++
 rtl/rtc_time_reader.sv | 211 +++++++++++++++++++++
 tb/tb_rtc_time_reader.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// RTC time reader shared definitions: FSM state encoding and I2C transfer constants.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t             - reader FSM states
//   RTC_ADDRESS_DEFAULT - 7-bit I2C address of a DS1307-style RTC
//   RTC_REG_POINTER     - register pointer written before the read (seconds register)
//   RTC_BYTES_TO_SEND   - number of bytes in the write phase (just the pointer)
//   RTC_BYTES_TO_READ   - number of bytes read back (seconds, minutes, hours)
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DECODE    = 3'd4
    } state_t;

    localparam logic [6:0] RTC_ADDRESS_DEFAULT = 7'h68;
    localparam logic [7:0] RTC_REG_POINTER     = 8'h00;
    localparam logic [4:0] RTC_BYTES_TO_SEND   = 5'd1;
    localparam logic [4:0] RTC_BYTES_TO_READ   = 5'd3;

endpackage

// File: rtl/rtc_time_reader_if.sv
// Command/response bundle between the RTC time reader and a generic I2C master.
// Latency: n/a (wires only).
// Backpressure: i2cReady low means the I2C master is busy; a start is only issued while it is high.
//
// Signals:
//   i2cStart               - one-cycle start pulse (reader -> I2C master)
//   i2cAddress             - 7-bit target address
//   i2cNrOfBytesToSend     - write-phase byte count
//   i2cBytesToSend         - write-phase payload, byte 0 sent first
//   i2cNrOfBytesToRead     - read-phase byte count
//   i2cBytesRead           - read payload, first received byte at the highest used index
//   i2cReady               - I2C master idle
//   i2cClockStretchTimeout - I2C master error flag
//   i2cNoAck               - I2C master error flag
// Modports: master = the reader that issues transactions, slave = the I2C engine that serves them.
interface rtc_time_reader_if;

    logic             i2cStart;
    logic [6:0]       i2cAddress;
    logic [4:0]       i2cNrOfBytesToSend;
    logic [15:0][7:0] i2cBytesToSend;
    logic [4:0]       i2cNrOfBytesToRead;
    logic [15:0][7:0] i2cBytesRead;
    logic             i2cReady;
    logic             i2cClockStretchTimeout;
    logic             i2cNoAck;

    modport master (
        output i2cStart,
        output i2cAddress,
        output i2cNrOfBytesToSend,
        output i2cBytesToSend,
        output i2cNrOfBytesToRead,
        input  i2cBytesRead,
        input  i2cReady,
        input  i2cClockStretchTimeout,
        input  i2cNoAck
    );

    modport slave (
        input  i2cStart,
        input  i2cAddress,
        input  i2cNrOfBytesToSend,
        input  i2cBytesToSend,
        input  i2cNrOfBytesToRead,
        output i2cBytesRead,
        output i2cReady,
        output i2cClockStretchTimeout,
        output i2cNoAck
    );

endinterface

// File: rtl/bcd_to_binary.sv
// Two-digit packed BCD to binary converter with digit-range flag.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_bcd         - packed BCD, tens in [7:4], units in [3:0]
//   o_binary      - tens*10 + units, truncated to 7 bits
//   o_digitsValid - both nibbles are 0..9
module bcd_to_binary (
    input  logic [7:0] i_bcd,
    output logic [6:0] o_binary,
    output logic       o_digitsValid
);

    logic [3:0] w_tens;
    logic [3:0] w_units;

    assign w_tens  = i_bcd[7:4];
    assign w_units = i_bcd[3:0];

    // 7-bit arithmetic wraps modulo 128, which is exactly truncation of the full result.
    assign o_binary      = ({3'b000, w_tens} * 7'd10) + {3'b000, w_units};
    assign o_digitsValid = (w_tens <= 4'd9) && (w_units <= 4'd9);

endmodule

// File: rtl/rtc_time_reader.sv
// Periodically (or on refresh) reads seconds/minutes/hours from an I2C RTC and decodes them to binary.
// Latency: start issued the cycle after the trigger; time outputs update one cycle after the read completes.
// Backpressure: a start is only issued while i2cReady is high; refreshes arriving mid-transaction merge into one pending read.
//
// Ports:
//   clock, reset (async, active-high)
//   refresh   - one-cycle pulse requesting an immediate read
//   bus       - rtc_time_reader_if.master towards the I2C engine
//   seconds, minutes, hours - last good decoded time (binary)
//   timeValid - time outputs hold a good decoded read
//   error     - last transaction or decode failed
// Build option: define RTC_BCD_CHECK_EN to reject non-decimal digits and out-of-range fields.
module rtc_time_reader
    import rtc_pkg::*;
#(
    parameter int unsigned ClockFrequency    = 1000000,
    parameter int unsigned PollPeriodMs      = 1000,
    parameter logic [6:0]  RtcAddress        = RTC_ADDRESS_DEFAULT,
    parameter int unsigned BusyTimeoutCycles = 4 * (ClockFrequency / 1000)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      refresh,
    rtc_time_reader_if.master         bus,
    output logic [5:0]                seconds,
    output logic [5:0]                minutes,
    output logic [4:0]                hours,
    output logic                      timeValid,
    output logic                      error
);

    localparam logic [31:0] POLL_LIMIT = 32'(PollPeriodMs * (ClockFrequency / 1000) - 1);
    localparam logic [31:0] BUSY_LIMIT = 32'(BusyTimeoutCycles - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_poll_cnt;
    logic [31:0] r_busy_cnt;
    logic        r_pending;
    logic [5:0]  r_seconds;
    logic [5:0]  r_minutes;
    logic [4:0]  r_hours;
    logic        r_time_valid;
    logic        r_error;

    logic        w_start;
    logic        w_go;
    logic        w_fail;
    logic        w_ok;
    logic        w_poll_expired;
    logic        w_decode_ok;

    logic [6:0]  w_sec_bin;
    logic [6:0]  w_min_bin;
    logic [6:0]  w_hr_bin;
    logic        w_sec_digits_ok;
    logic        w_min_digits_ok;
    logic        w_hr_digits_ok;
    logic        w_unused_ok;

    // Fixed transfer description: write the register pointer, read three bytes back.
    assign bus.i2cAddress         = RtcAddress;
    assign bus.i2cNrOfBytesToSend = RTC_BYTES_TO_SEND;
    assign bus.i2cBytesToSend     = {{15{8'h00}}, RTC_REG_POINTER};
    assign bus.i2cNrOfBytesToRead = RTC_BYTES_TO_READ;
    assign bus.i2cStart           = w_start;

    assign seconds   = r_seconds;
    assign minutes   = r_minutes;
    assign hours     = r_hours;
    assign timeValid = r_time_valid;
    assign error     = r_error;

    // The first byte received (seconds register) lands at the highest index.
    // Seconds bit 7 is the RTC clock-halt flag; hours bits 7:6 are mode bits, not digits.
    bcd_to_binary u_bcd_sec (
        .i_bcd        ({1'b0, bus.i2cBytesRead[2][6:0]}),
        .o_binary     (w_sec_bin),
        .o_digitsValid(w_sec_digits_ok)
    );

    bcd_to_binary u_bcd_min (
        .i_bcd        (bus.i2cBytesRead[1]),
        .o_binary     (w_min_bin),
        .o_digitsValid(w_min_digits_ok)
    );

    bcd_to_binary u_bcd_hr (
        .i_bcd        ({2'b00, bus.i2cBytesRead[0][5:0]}),
        .o_binary     (w_hr_bin),
        .o_digitsValid(w_hr_digits_ok)
    );

    // 12-hour mode (hours bit 6) cannot be represented in the 0..23 output.
`ifdef RTC_BCD_CHECK_EN
    assign w_decode_ok = !bus.i2cBytesRead[0][6]
                       && w_sec_digits_ok && w_min_digits_ok && w_hr_digits_ok
                       && (w_sec_bin <= 7'd59) && (w_min_bin <= 7'd59) && (w_hr_bin <= 7'd23);
`else
    assign w_decode_ok = !bus.i2cBytesRead[0][6];
`endif

    // Bytes beyond the three read and bits dropped by truncation are intentionally ignored.
    assign w_unused_ok = ^{bus.i2cBytesRead[15:3], bus.i2cBytesRead[2][7], bus.i2cBytesRead[0][7],
                           w_sec_bin[6], w_min_bin[6], w_hr_bin[6:5],
                           w_sec_digits_ok, w_min_digits_ok, w_hr_digits_ok};

    assign w_poll_expired = (r_poll_cnt >= POLL_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_go         = 1'b0;
        w_fail       = 1'b0;
        w_ok         = 1'b0;
        case (r_state)
            ST_WAIT: begin
                // A refresh in the same cycle as poll expiry still yields one transaction.
                if ((w_poll_expired || r_pending || refresh) && bus.i2cReady) begin
                    w_go         = 1'b1;
                    w_state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                w_start      = 1'b1;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.i2cReady) begin
                    w_state_next = ST_WAIT_DONE;
                end else if (r_busy_cnt >= BUSY_LIMIT) begin
                    w_fail       = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.i2cReady) begin
                    if (bus.i2cNoAck || bus.i2cClockStretchTimeout) begin
                        w_fail       = 1'b1;
                        w_state_next = ST_WAIT;
                    end else begin
                        w_state_next = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                w_ok         = w_decode_ok;
                w_fail       = !w_decode_ok;
                w_state_next = ST_WAIT;
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_poll_cnt   <= '0;
            r_busy_cnt   <= '0;
            r_pending    <= 1'b0;
            r_seconds    <= '0;
            r_minutes    <= '0;
            r_hours      <= '0;
            r_time_valid <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Poll counter only advances while idle and saturates at expiry until the master is free.
            if (w_go) begin
                r_poll_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !w_poll_expired) begin
                r_poll_cnt <= r_poll_cnt + 32'd1;
            end

            if (r_state == ST_REQUEST) begin
                r_busy_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end

            // Refreshes merge into a single pending request, consumed by the transaction being launched.
            if (w_go) begin
                r_pending <= 1'b0;
            end else if (refresh) begin
                r_pending <= 1'b1;
            end

            if (w_fail) begin
                r_error <= 1'b1;
            end

            // All three fields update in one edge so no mixed old/new time is ever visible.
            if (w_ok) begin
                r_seconds    <= w_sec_bin[5:0];
                r_minutes    <= w_min_bin[5:0];
                r_hours      <= w_hr_bin[4:0];
                r_time_valid <= 1'b1;
                r_error      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Scoreboard bench for rtc_time_reader with a behavioural I2C master model.
// Latency: n/a.
// Backpressure: model holds i2cReady low for a programmable busy time.
module tb_rtc_time_reader;

    localparam int BUSY = 40;  // 4 * (10000 / 1000)

    typedef struct packed {
        logic       abort;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
        logic       valid;
        logic       err;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       refresh;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       timeValid;
    logic       error;

    rtc_time_reader_if bus_if ();

    rtc_time_reader #(
        .ClockFrequency(10000),
        .PollPeriodMs  (20)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .refresh  (refresh),
        .bus      (bus_if),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
        .timeValid(timeValid),
        .error    (error)
    );

    int   checks   = 0;
    int   failures = 0;
    int   mon_done = 0;
    exp_t exp_q[$];

    // Master model controls
    logic [7:0] mdl_b2, mdl_b1, mdl_b0;
    logic       mdl_noack, mdl_stretch, mdl_stuck;
    int         mdl_drop, mdl_busy;

    // Last good time as the bench expects it to be held
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hr;
    logic       cur_valid;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // I2C master model: answers each start after mdl_drop idle cycles and mdl_busy busy cycles.
    initial begin : master_model
        bit abort;
        bus_if.i2cReady               = 1'b1;
        bus_if.i2cNoAck               = 1'b0;
        bus_if.i2cClockStretchTimeout = 1'b0;
        bus_if.i2cBytesRead           = '0;
        forever begin
            @(negedge clock);
            if (!reset && bus_if.i2cStart && !mdl_stuck) begin
                abort = 1'b0;
                bus_if.i2cNoAck               = 1'b0;
                bus_if.i2cClockStretchTimeout = 1'b0;
                for (int k = 0; k < mdl_drop; k++) begin
                    @(negedge clock);
                    if (reset) begin abort = 1'b1; break; end
                end
                if (!abort) begin
                    bus_if.i2cReady = 1'b0;
                    for (int k = 0; k < mdl_busy; k++) begin
                        @(negedge clock);
                        if (reset) begin abort = 1'b1; break; end
                    end
                end
                if (!abort) begin
                    bus_if.i2cBytesRead[2]        = mdl_b2;
                    bus_if.i2cBytesRead[1]        = mdl_b1;
                    bus_if.i2cBytesRead[0]        = mdl_b0;
                    bus_if.i2cNoAck               = mdl_noack;
                    bus_if.i2cClockStretchTimeout = mdl_stretch;
                end
                bus_if.i2cReady = 1'b1;
            end
        end
    end

    // Monitor: every start pops one expectation and checks the outputs once that transaction settles.
    initial begin : monitor
        exp_t e;
        bit   fin, seen_low;
        @(negedge clock);
        forever begin
            if (!reset && bus_if.i2cStart) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: actual=start required=none at %0t", $time);
                    @(negedge clock);
                end else begin
                    e = exp_q.pop_front();
                    if (e.abort) begin
                        fin = 1'b0;
                        for (int n = 0; n < 50 && !fin; n++) begin
                            @(negedge clock);
                            if (reset) fin = 1'b1;
                        end
                        if (!fin) begin
                            checks++;
                            failures++;
                            $display("FAIL abort_wait: actual=no reset required=reset at %0t", $time);
                        end else begin
                            #1;
                            check("rst_seconds", 128'(seconds), 128'(e.sec));
                            check("rst_minutes", 128'(minutes), 128'(e.min));
                            check("rst_hours", 128'(hours), 128'(e.hr));
                            check("rst_timeValid", 128'(timeValid), 128'(e.valid));
                            check("rst_error", 128'(error), 128'(e.err));
                            check("rst_i2cStart", 128'(bus_if.i2cStart), 128'(0));
                        end
                    end else begin
                        fin      = 1'b0;
                        seen_low = 1'b0;
                        for (int n = 0; n < 400 && !fin; n++) begin
                            @(negedge clock);
                            if (!bus_if.i2cReady) seen_low = 1'b1;
                            else if (seen_low) fin = 1'b1;
                            else if (n >= BUSY + 10) fin = 1'b1;
                        end
                        if (!fin) begin
                            checks++;
                            failures++;
                            $display("FAIL txn_wait: actual=unfinished required=finished at %0t", $time);
                        end else begin
                            repeat (2) @(negedge clock);
                            check("seconds", 128'(seconds), 128'(e.sec));
                            check("minutes", 128'(minutes), 128'(e.min));
                            check("hours", 128'(hours), 128'(e.hr));
                            check("timeValid", 128'(timeValid), 128'(e.valid));
                            check("error", 128'(error), 128'(e.err));
                        end
                    end
                    mon_done++;
                end
            end else begin
                @(negedge clock);
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(negedge clock);
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic set_bytes(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        mdl_b2 = b2;
        mdl_b1 = b1;
        mdl_b0 = b0;
    endtask

    task automatic push_ok(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
        exp_t e;
        cur_sec   = s;
        cur_min   = m;
        cur_hr    = h;
        cur_valid = 1'b1;
        e.abort = 1'b0; e.sec = s; e.min = m; e.hr = h; e.valid = 1'b1; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.abort = 1'b0; e.sec = cur_sec; e.min = cur_min; e.hr = cur_hr;
        e.valid = cur_valid; e.err = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_abort();
        exp_t e;
        e = '0;
        e.abort = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic pulse_refresh();
        @(negedge clock);
        refresh = 1'b1;
        @(negedge clock);
        refresh = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int k = 0; k < bound && mon_done < target; k++) @(negedge clock);
        checks++;
        if (mon_done < target) begin
            failures++;
            $display("FAIL wait_done: actual=%0d required=%0d at %0t", mon_done, target, $time);
        end
    endtask

    initial begin : stimulus
        int n_txn;
        n_txn       = 0;
        reset       = 1'b1;
        refresh     = 1'b0;
        mdl_noack   = 1'b0;
        mdl_stretch = 1'b0;
        mdl_stuck   = 1'b0;
        mdl_drop    = 0;
        mdl_busy    = 3;
        set_bytes(8'h00, 8'h00, 8'h00);
        cur_sec = '0; cur_min = '0; cur_hr = '0; cur_valid = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_seconds", 128'(seconds), 128'(0));
        check("reset_minutes", 128'(minutes), 128'(0));
        check("reset_hours", 128'(hours), 128'(0));
        check("reset_timeValid", 128'(timeValid), 128'(0));
        check("reset_error", 128'(error), 128'(0));
        check("reset_i2cStart", 128'(bus_if.i2cStart), 128'(0));
        check("i2cAddress", 128'(bus_if.i2cAddress), 128'(7'h68));
        check("nr_send", 128'(bus_if.i2cNrOfBytesToSend), 128'(1));
        check("nr_read", 128'(bus_if.i2cNrOfBytesToRead), 128'(3));
        check("bytes_to_send", bus_if.i2cBytesToSend, 128'(0));
        reset = 1'b0;

        // Basic read
        set_bytes(8'h45, 8'h30, 8'h13);
        push_ok(6'd45, 6'd30, 5'd13);
        pulse_refresh();
        wait_done(++n_txn, 200);

        // Clock-halt bit on seconds is masked
        set_bytes(8'hC5, 8'h59, 8'h23);
        push_ok(6'd45, 6'd59, 5'd23);
        pulse_refresh();
        wait_done(++n_txn, 200);

        // NoAck at completion: error, previous time held
        set_bytes(8'h00, 8'h00, 8'h00);
        mdl_noack = 1'b1;
        push_err();
        pulse_refresh();
        wait_done(++n_txn, 200);
        mdl_noack = 1'b0;

        // Clock-stretch timeout flag: same handling
        mdl_stretch = 1'b1;
        push_err();
        pulse_refresh();
        wait_done(++n_txn, 200);
        mdl_stretch = 1'b0;

        // Minutes 8'h6A: rejected with range checks, else 70 truncated to 6
        set_bytes(8'h12, 8'h6A, 8'h08);
`ifdef RTC_BCD_CHECK_EN
        push_err();
`else
        push_ok(6'd12, 6'd6, 5'd8);
`endif
        pulse_refresh();
        wait_done(++n_txn, 200);

        // 12-hour mode hours byte is a decode failure
        set_bytes(8'h01, 8'h02, 8'h52);
        push_err();
        pulse_refresh();
        wait_done(++n_txn, 200);

        // Master never goes busy: timeout error, then the next poll starts a fresh read
        mdl_stuck = 1'b1;
        push_err();
        pulse_refresh();
        wait_done(++n_txn, 200);
        mdl_stuck = 1'b0;
        set_bytes(8'h07, 8'h08, 8'h09);
        push_ok(6'd7, 6'd8, 5'd9);
        wait_done(++n_txn, 400);

        // Three refreshes while busy merge into exactly one extra transaction
        mdl_busy = 20;
        set_bytes(8'h59, 8'h00, 8'h00);
        push_ok(6'd59, 6'd0, 5'd0);
        push_ok(6'd59, 6'd0, 5'd0);
        pulse_refresh();
        for (int k = 0; k < 20 && !bus_if.i2cStart; k++) @(negedge clock);
        repeat (5) @(negedge clock);
        pulse_refresh();
        pulse_refresh();
        pulse_refresh();
        n_txn += 2;
        wait_done(n_txn, 300);
        repeat (100) @(negedge clock);
        check("merge_queue_empty", 128'(exp_q.size()), 128'(0));
        mdl_busy = 3;

        // Reset during WaitBusy: outputs clear, no start until the next refresh
        mdl_drop = 15;
        push_abort();
        pulse_refresh();
        repeat (4) @(negedge clock);
        reset = 1'b1;
        cur_sec = '0; cur_min = '0; cur_hr = '0; cur_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        mdl_drop = 0;
        wait_done(++n_txn, 50);
        repeat (150) @(negedge clock);
        set_bytes(8'h33, 8'h22, 8'h11);
        push_ok(6'd33, 6'd22, 5'd11);
        pulse_refresh();
        wait_done(++n_txn, 200);

        repeat (5) @(negedge clock);
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
